// File: rtl/act_stream_pkg.sv
// Shared types and helpers for the activation stream collector.
package act_stream_pkg;

    // Fractional bits of the 8.8 activation format (data passes through untouched).
    localparam int Q_FRAC = 8;
    localparam int N_DEF  = 16;

    typedef logic signed [N_DEF-1:0] data_t;

    typedef enum logic {
        BANK_FILLING = 1'b0,
        BANK_FULL    = 1'b1
    } bank_state_e;

    // Channel index width; never below one bit so single-channel builds still have a port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collector_bank.sv
// One ping-pong bank: CHANNELS words plus a presence mask.
// clr empties the mask; stored words are left in place until overwritten.
module collector_bank
    import act_stream_pkg::*;
#(
    parameter int N        = 16,
    parameter int CHANNELS = 16,
    parameter int CH_W     = ch_w(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [N-1:0]          wr_data,
    input  logic                  clr,
    output logic [N*CHANNELS-1:0] words,
    output logic [CHANNELS-1:0]   mask,
    output bank_state_e           state,
    output logic                  full_nxt
);

    logic [N*CHANNELS-1:0] words_q, words_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;

    // Next contents: clear first, then a write may set its bit in the same cycle.
    always_comb begin
        words_d = words_q;
        mask_d  = clr ? '0 : mask_q;
        if (wr_en) begin
            words_d[int'(wr_ch)*N +: N] = wr_data;
            mask_d[wr_ch]               = 1'b1;
        end
    end

    // Bank storage and mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            mask_q  <= '0;
        end else begin
            words_q <= words_d;
            mask_q  <= mask_d;
        end
    end

    assign words    = words_q;
    assign mask     = mask_q;
    assign state    = (&mask_q) ? BANK_FULL : BANK_FILLING;
    assign full_nxt = &mask_d;

endmodule

// File: rtl/channel_stream_collector.sv
// Collects per-channel activation words into full pixel vectors and hands them
// out on a valid/ready port, ping-ponging between two banks so the producer
// never stalls. Optional strict ascending-order checking: COLLECT_ORDER_CHECK_EN.
module channel_stream_collector
    import act_stream_pkg::*;
#(
    parameter int N        = 16,
    parameter int CHANNELS = 16,
    parameter int CH_W     = ch_w(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          data_in,
    input  logic [CH_W-1:0]       channel_in,
    input  logic                  valid_in,
    output logic [N*CHANNELS-1:0] vec_out,
    output logic                  vec_valid,
    input  logic                  vec_ready,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  protocol_err
);

    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic vec_valid_q, vec_valid_d;
    logic ovf_q, ovf_d;
    logic perr_q, perr_d;
`ifdef COLLECT_ORDER_CHECK_EN
    logic [CH_W-1:0] exp_q, exp_d;
`endif

    logic [1:0]                     wr_en_b, clr_b, full_nxt_b;
    logic [1:0][N*CHANNELS-1:0]     words_b;
    logic [1:0][CHANNELS-1:0]       mask_b;
    bank_state_e                    state_b [2];

    logic                cur_full, in_range, hs, wr_en, part_clr, complete;
    logic                ovf_set, perr_set;
    logic [CHANNELS-1:0] cur_mask, base_mask, onehot;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        collector_bank #(.N(N), .CHANNELS(CHANNELS), .CH_W(CH_W)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en_b[b]),
            .wr_ch    (channel_in),
            .wr_data  (data_in),
            .clr      (clr_b[b]),
            .words    (words_b[b]),
            .mask     (mask_b[b]),
            .state    (state_b[b]),
            .full_nxt (full_nxt_b[b])
        );
    end

    // Write-side decision, bank pointers and sticky flag updates.
    always_comb begin
        cur_full  = (state_b[wr_bank_q] == BANK_FULL);
        cur_mask  = mask_b[wr_bank_q];
        in_range  = (int'(channel_in) < CHANNELS);
        onehot    = '0;
        if (in_range) onehot[channel_in] = 1'b1;
        hs        = vec_valid_q && vec_ready;
        wr_en     = 1'b0;
        part_clr  = 1'b0;
        ovf_set   = 1'b0;
        perr_set  = 1'b0;
        base_mask = cur_mask;
`ifdef COLLECT_ORDER_CHECK_EN
        exp_d     = exp_q;
`endif
        if (valid_in) begin
            // A full write bank means both banks are occupied: drop, counter untouched.
            if (cur_full) begin
                ovf_set = 1'b1;
`ifdef COLLECT_ORDER_CHECK_EN
            end else if (channel_in != exp_q) begin
                // Out-of-order word abandons the partial vector; a ch0 restarts it.
                perr_set  = 1'b1;
                part_clr  = 1'b1;
                base_mask = '0;
                if (channel_in == '0) begin
                    wr_en = 1'b1;
                    exp_d = CH_W'(1);
                end else begin
                    exp_d = '0;
                end
            end else begin
                wr_en = 1'b1;
                exp_d = (exp_q == CH_W'(CHANNELS-1)) ? '0 : exp_q + CH_W'(1);
            end
`else
            end else if (!in_range || ((cur_mask & onehot) != '0)) begin
                perr_set = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
`endif
        end
        complete  = wr_en && (&(base_mask | onehot));
        wr_bank_d = wr_bank_q ^ complete;
        rd_bank_d = rd_bank_q ^ hs;

        wr_en_b            = '0;
        wr_en_b[wr_bank_q] = wr_en;
        clr_b              = '0;
        clr_b[rd_bank_q]   = hs;
        if (part_clr) clr_b[wr_bank_q] = 1'b1;

        ovf_d  = (ovf_q  & ~clr_err) | ovf_set;
        perr_d = (perr_q & ~clr_err) | perr_set;
    end

    // Valid tracks the post-edge fullness of whichever bank will be read next.
    always_comb begin
        vec_valid_d = full_nxt_b[rd_bank_d];
    end

    // Pointer, valid and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
`ifdef COLLECT_ORDER_CHECK_EN
            exp_q       <= '0;
`endif
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            vec_valid_q <= vec_valid_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
`ifdef COLLECT_ORDER_CHECK_EN
            exp_q       <= exp_d;
`endif
        end
    end

    assign vec_out      = rd_bank_q ? words_b[1] : words_b[0];
    assign vec_valid    = vec_valid_q;
    assign overflow     = ovf_q;
    assign protocol_err = perr_q;

endmodule

// File: doc/channel_stream_collector.md
Name: channel_stream_collector

Overview:
- Receiving end of the per-channel activation stream (`data`/`channel`/`valid`, no backpressure) produced by the bneck activation stages.
- Gathers one word per channel into a full pixel vector of CHANNELS words.
- Presents each completed vector on a valid/ready interface to the next bneck stage (pointwise conv / SE block).
- Ping-pong buffered, so upstream is never stalled while one vector waits for the consumer.

Parameters:
- N, 16, data word width (8.8 signed fixed point, passed through unmodified)
- CHANNELS, 16, words per vector; CH_W = $clog2(CHANNELS)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- data_in  input  N  activation word
- channel_in  input  CH_W  channel index of data_in
- valid_in  input  1  data_in/channel_in valid this cycle
- vec_out  output  N*CHANNELS  completed vector; channel c at bits [c*N +: N]
- vec_valid  output  1  vec_out holds a complete vector
- vec_ready  input  1  consumer accepts vec_out
- clr_err  input  1  clears the sticky error flags
- overflow  output  1  sticky: word dropped because both banks were full
- protocol_err  output  1  sticky: duplicate or out-of-range channel (or order violation, see below)

Behaviour:
- Reset state (rst=1 at a clock edge):
  - banks 0 and 1 empty (mask=0); wr_bank=0, rd_bank=0
  - vec_out=0, vec_valid=0, overflow=0, protocol_err=0
  - rst mid-vector discards all partial and complete data
- Each bank holds CHANNELS words plus a CHANNELS-bit mask; the bank is FULL when the mask is all ones.
- Write side, on valid_in=1:
  - If bank[wr_bank] is FULL, the word is dropped and overflow is set.
  - Else if channel_in >= CHANNELS, or mask[channel_in] is already set, the word is dropped and protocol_err is set; stored data is unchanged.
  - Else the word is stored in bank[wr_bank][channel_in] and the mask bit is set.
  - When that write completes the mask, wr_bank toggles on the same edge.
- Read side:
  - vec_valid = bank[rd_bank] FULL, registered.
  - vec_out is driven from bank[rd_bank] storage and is stable while vec_valid=1 and vec_ready=0.
  - On vec_valid && vec_ready, bank[rd_bank] mask clears and rd_bank toggles.
- Latency: the edge that writes the last word of a vector raises vec_valid for the following cycle, provided rd_bank points at that bank.
- Simultaneous events:
  - A read handshake freeing bank X and a write to the other bank in the same cycle are both honoured.
  - A write arriving when wr_bank points at a FULL bank being released the same cycle is dropped (overflow set); no same-cycle bypass.
  - Back-to-back vectors with vec_ready held high sustain full throughput, one word per cycle.
- Sticky flags:
  - Set by the events above; cleared by clr_err.
  - If clr_err and a new error occur in the same cycle, the flag ends set.
- Data is never modified, saturated or sign-adjusted.

Optional Feature:
- Macro: COLLECT_ORDER_CHECK_EN
- Defined:
  - An expected-channel counter (0..CHANNELS-1, wrapping) enforces strict ascending order.
  - A word with channel_in != expected sets protocol_err and clears the partial mask of bank[wr_bank]; the counter resets to 0.
  - If that offending word has channel_in=0, it is accepted as the start of a new vector and the counter becomes 1.
  - Overflow drops do not advance the counter.
- Undefined: any arrival order is accepted; completion is decided by the mask only.

Decomposition:
- Package act_stream_pkg holds:
  - ch_w function ($clog2 wrapper)
  - data_t (logic signed [N-1:0]) typedef
  - bank-state enum {BANK_FILLING, BANK_FULL}
  - shared localparams Q_FRAC=8
- One natural sub-module, collector_bank: per-bank storage, mask, full flag, clear port. Instantiated twice.
- Top level holds the pointers, flags and order checker.

Test Plan (CHANNELS=4, N=16):
- Send channels 0..3 with data 0x0100, 0x0200, 0xFF00, 0x0600, vec_ready=1 → vec_valid high one cycle after the last word; vec_out=0x0600_FF00_0200_0100; handshake that cycle; no flags.
- Send three vectors back-to-back with vec_ready=0 → first two complete; every word of the third is dropped; overflow=1; raise vec_ready → vectors 1 then 2 delivered in order with correct data.
- Send channel order 2,0,2,1,3 (order check off) → second ch2 dropped, protocol_err=1; vector completes with the first ch2 data.
- With COLLECT_ORDER_CHECK_EN, send 0,1,3,0,1,2,3 → protocol_err set at ch3; the ch0 that follows restarts the vector; one vector delivered equal to the last four words.
- Assert rst after two words of a vector, then send a full vector → only the post-reset vector appears; flags 0; assert clr_err with a simultaneous duplicate → protocol_err remains 1.
